// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type and PS/2 prefix byte codes for the keyboard receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronisers for the PS/2 lines plus ps2_clk falling-edge detect.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);
    logic [2:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
    end

    // Reset to the idle line level so releasing reset never fakes a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s = data_sync_q[1];
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 frame receiver and make/break/extended decoder.
// kb_code holds the pressed key's make code and drops to 0 on its release.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kb_code,
    output logic       extended,
    output logic       code_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall, data_s;
    ps2_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
    logic [7:0] kb_code_q, kb_code_d;
    logic extended_q, extended_d, code_valid_q, code_valid_d, frame_err_q, frame_err_d;

    ps2_sync_edge u_sync (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .fall    (fall),
        .data_s  (data_s)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;
        brk_pend_d   = brk_pend_q;
        ext_pend_d   = ext_pend_q;
        kb_code_d    = kb_code_q;
        extended_d   = extended_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!(data_s && (^shift_q ^ par_q))) begin
                        frame_err_d = 1'b1;
                    end else if (shift_q == PS2_BREAK) begin
                        brk_pend_d = 1'b1;
                    end else if (shift_q == PS2_EXT) begin
                        ext_pend_d = 1'b1;
                    end else begin
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                        if (!brk_pend_q) begin
                            kb_code_d    = shift_q;
                            extended_d   = ext_pend_q;
                            code_valid_d = 1'b1;
                        end else if (shift_q == kb_code_q) begin
                            kb_code_d    = '0;
                            extended_d   = 1'b0;
                            code_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = IDLE;
            shift_d     = '0;
            bit_cnt_d   = '0;
            frame_err_d = 1'b1;
        end
        // Any framing error invalidates a half-received F0/E0 prefix sequence.
        if (frame_err_d) begin
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
            kb_code_q    <= '0;
            extended_q   <= 1'b0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            brk_pend_q   <= brk_pend_d;
            ext_pend_q   <= ext_pend_d;
            kb_code_q    <= kb_code_d;
            extended_q   <= extended_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign kb_code    = kb_code_q;
    assign extended   = extended_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: drives PS/2 frames into ps2_keyboard_rx and checks it against a key-state model.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int TMO = 300;
    localparam int H   = 20;

    logic clk = 1'b0;
    logic reset, ps2_clk, ps2_data;
    logic [7:0] kb_code;
    logic extended, code_valid, frame_err;

    int checks = 0;
    int errors = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int rule_viol = 0;
    bit prev_pulse = 1'b0;

    logic [7:0] m_kb;
    bit m_ext, m_brk, m_extp;

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kb_code   (kb_code),
        .extended  (extended),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
        if ((code_valid && frame_err) || ((code_valid || frame_err) && prev_pulse)) rule_viol++;
        prev_pulse = code_valid || frame_err;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Key-state model: what a keyboard user would see after each received byte.
    task automatic model_byte(input logic [7:0] b, output bit pulse);
        pulse = 1'b0;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_extp = 1'b1;
        else begin
            if (!m_brk) begin
                m_kb  = b;
                m_ext = m_extp;
                pulse = 1'b1;
            end else if (b == m_kb) begin
                m_kb  = 8'h00;
                m_ext = 1'b0;
                pulse = 1'b1;
            end
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, output int lat);
        logic [10:0] f;
        f   = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            for (int k = 1; k <= H; k++) begin
                @(negedge clk);
                if (lat == 0 && (code_valid || frame_err)) lat = k;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic do_frame(input string name, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int cv0, fe0, lat;
        bit exp_cv, exp_fe;
        exp_fe = bad_par || bad_stop;
        exp_cv = 1'b0;
        if (exp_fe) begin
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end else model_byte(b, exp_cv);
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(b, bad_par, bad_stop, 11, lat);
        checks += 4;
        if (kb_code !== m_kb) begin errors++; $display("FAIL %s kb_code: got %h want %h", name, kb_code, m_kb); end
        if (extended !== m_ext) begin errors++; $display("FAIL %s extended: got %b want %b", name, extended, m_ext); end
        if (cv_cnt - cv0 != int'(exp_cv)) begin errors++; $display("FAIL %s code_valid pulses: got %0d want %0d", name, cv_cnt - cv0, exp_cv); end
        if (fe_cnt - fe0 != int'(exp_fe)) begin errors++; $display("FAIL %s frame_err pulses: got %0d want %0d", name, fe_cnt - fe0, exp_fe); end
        if (exp_cv || exp_fe) begin
            checks++;
            if (lat < 3 || lat > 4) begin errors++; $display("FAIL %s pulse latency: got %0d want 3..4", name, lat); end
        end
    endtask

    task automatic test_reset();
        ps2_clk = 1'b1; ps2_data = 1'b1; reset = 1'b1;
        m_kb = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_extp = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (kb_code !== 8'h00) begin errors++; $display("FAIL reset kb_code: got %h want 00", kb_code); end
        if (extended !== 1'b0) begin errors++; $display("FAIL reset extended: got %b want 0", extended); end
        if (code_valid !== 1'b0) begin errors++; $display("FAIL reset code_valid: got %b want 0", code_valid); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_make_break();
        do_frame("make23", 8'h23, 0, 0);
        do_frame("brk_f0", 8'hF0, 0, 0);
        do_frame("brk23", 8'h23, 0, 0);
    endtask

    task automatic test_extended();
        do_frame("ext_e0", 8'hE0, 0, 0);
        do_frame("ext75", 8'h75, 0, 0);
        do_frame("extbrk_e0", 8'hE0, 0, 0);
        do_frame("extbrk_f0", 8'hF0, 0, 0);
        do_frame("extbrk75", 8'h75, 0, 0);
    endtask

    task automatic test_other_release();
        do_frame("oth_make23", 8'h23, 0, 0);
        do_frame("oth_f0", 8'hF0, 0, 0);
        do_frame("oth_rel1c", 8'h1C, 0, 0);
        do_frame("oth_make1c", 8'h1C, 0, 0);
        do_frame("typematic1c", 8'h1C, 0, 0);
    endtask

    task automatic test_errors();
        do_frame("badpar23", 8'h23, 1, 0);
        do_frame("badstop23", 8'h23, 0, 1);
        do_frame("err_f0", 8'hF0, 0, 0);
        do_frame("err_clears_brk", 8'h14, 1, 0);
        do_frame("after_err_1c", 8'h1C, 0, 0);
    endtask

    task automatic test_timeout();
        int fe0, cv0, lat;
        do_frame("to_pre_e0", 8'hE0, 0, 0);
        fe0 = fe_cnt;
        cv0 = cv_cnt;
        send_frame(8'h29, 0, 0, 5, lat);
        repeat (TMO + 20) @(negedge clk);
        m_brk = 1'b0;
        m_extp = 1'b0;
        checks += 4;
        if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL timeout frame_err pulses: got %0d want 1", fe_cnt - fe0); end
        if (cv_cnt != cv0) begin errors++; $display("FAIL timeout code_valid pulses: got %0d want 0", cv_cnt - cv0); end
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL timeout state: got %0d want IDLE", dut.state_q); end
        if (kb_code !== m_kb) begin errors++; $display("FAIL timeout kb_code: got %h want %h", kb_code, m_kb); end
        do_frame("to_after29", 8'h29, 0, 0);
    endtask

    task automatic test_reset_midframe();
        int lat;
        send_frame(8'h5A, 0, 0, 6, lat);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_kb = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_extp = 1'b0;
        @(negedge clk);
        checks += 3;
        if (kb_code !== 8'h00) begin errors++; $display("FAIL midreset kb_code: got %h want 00", kb_code); end
        if (extended !== 1'b0) begin errors++; $display("FAIL midreset extended: got %b want 0", extended); end
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL midreset state: got %0d want IDLE", dut.state_q); end
        do_frame("midreset_after29", 8'h29, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        for (int n = 0; n < 25; n++) begin
            r = int'($urandom_range(0, 5));
            b = 8'($urandom_range(1, 127));
            if (r == 0) b = 8'hF0;
            else if (r == 1) b = 8'hE0;
            else if (r == 2 && m_kb != 8'h00) b = m_kb;
            do_frame($sformatf("rand%0d_%h", n, b), b, 0, 0);
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (rule_viol != 0) begin errors++; $display("FAIL pulse_rules overlapping/consecutive pulses: got %0d want 0", rule_viol); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_other_release();
        test_errors();
        test_timeout();
        test_reset_midframe();
        test_random();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
